alu_cmd_sequencer: RTL and testbench

- Clocked command-side initiator for the combinational BreadBoard calculator datapath (IN1/IN2/OP in, OUT/ERR out).
- Accepts operation commands over a valid/ready channel and drives BreadBoard inputs from registers.
- Waits a fixed number of settle cycles, then captures OUT/ERR, masks ERR by opcode and returns the result over a valid/ready response channel.
- Keeps a 32-bit accumulator so results can chain into the next command.

---
 rtl/alu_seq_pkg.sv | 15 +
 rtl/alu_cmd_sequencer_if.sv | 28 ++
 rtl/alu_seq_err_mask.sv | 15 +
 rtl/alu_cmd_sequencer.sv | 107 ++++++++++
 tb/tb_alu_cmd_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and error-bit constants shared by the ALU command sequencer
package alu_seq_pkg;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_MOD = 4'b0110;
    localparam int ERR_OVF_BIT = 0;
    localparam int ERR_DZE_BIT = 1;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;
    typedef enum logic [1:0] {IDLE, SETTLE, RESPOND} state_t;
    function automatic logic is_legal(input logic [3:0] op);
        return op == OP_ADD || op == OP_SUB || op == OP_MUL || op == OP_DIV || op == OP_MOD;
    endfunction
endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, BreadBoard and response channels of the sequencer
interface alu_cmd_sequencer_if #(parameter int DATA_W = 16, parameter int RES_W = 32);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_in1;
    logic [DATA_W-1:0] cmd_in2;
    logic [3:0]        cmd_op;
    logic              cmd_acc;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [3:0]        alu_op;
    logic [RES_W-1:0]  alu_out;
    logic [1:0]        alu_err;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_out;
    logic [1:0]        rsp_err;
    logic [RES_W-1:0]  acc;
    logic              busy;
    modport master (
        output cmd_valid, cmd_in1, cmd_in2, cmd_op, cmd_acc, alu_out, alu_err, rsp_ready,
        input  cmd_ready, alu_in1, alu_in2, alu_op, rsp_valid, rsp_out, rsp_err, acc, busy
    );
    modport slave (
        input  cmd_valid, cmd_in1, cmd_in2, cmd_op, cmd_acc, alu_out, alu_err, rsp_ready,
        output cmd_ready, alu_in1, alu_in2, alu_op, rsp_valid, rsp_out, rsp_err, acc, busy
    );
endinterface

// File: rtl/alu_seq_err_mask.sv
// alu_seq_err_mask: keeps only the BreadBoard error bits meaningful for the issued opcode
module alu_seq_err_mask
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    input  logic [1:0] err,
    output logic [1:0] err_m,
    output logic       legal
);
    always_comb begin
        legal = is_legal(op);
        err_m = (op == OP_ADD || op == OP_SUB) ? {1'b0, err[ERR_OVF_BIT]} :
                (op == OP_DIV || op == OP_MOD) ? {err[ERR_DZE_BIT], 1'b0} : 2'b00;
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to the BreadBoard ALU, waits SETTLE_CYCLES, returns masked result; optional ALU_SEQ_ILLEGAL_OP_EN
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int DATA_W = 16,
    parameter int RES_W = 32
) (
    input logic clk,
    input logic rst,
    alu_cmd_sequencer_if.slave bus
);
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [RES_W-1:0]  rsp_out_q, rsp_out_d, acc_q, acc_d;
    logic [1:0]        rsp_err_q, rsp_err_d, err_m;
    logic              cmd_ready_q, cmd_ready_d, busy_q, busy_d;
    logic              legal, skip_issue;
    alu_seq_err_mask u_mask (.op(alu_op_q), .err(bus.alu_err), .err_m(err_m), .legal(legal));
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    assign skip_issue = !is_legal(bus.cmd_op);
`else
    assign skip_issue = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_out_d   = rsp_out_q;
        rsp_err_d   = rsp_err_q;
        acc_d       = acc_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                if (skip_issue) begin
                    state_d     = RESPOND;
                    rsp_valid_d = 1'b1;
                    rsp_out_d   = '0;
                    rsp_err_d   = ERR_ILLEGAL;
                end else begin
                    alu_in1_d = bus.cmd_acc ? acc_q[DATA_W-1:0] : bus.cmd_in1;
                    alu_in2_d = bus.cmd_in2;
                    alu_op_d  = bus.cmd_op;
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
                state_d     = RESPOND;
                rsp_valid_d = 1'b1;
                rsp_out_d   = bus.alu_out;
                rsp_err_d   = err_m;
                acc_d       = (err_m == 2'b00 && legal) ? bus.alu_out : acc_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            RESPOND: if (bus.rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = state_d == IDLE;
        busy_d      = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_op_q    <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_err_q   <= 2'b00;
            acc_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_out_q   <= rsp_out_d;
            rsp_err_q   <= rsp_err_d;
            acc_q       <= acc_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end
    assign bus.alu_in1   = alu_in1_q;
    assign bus.alu_in2   = alu_in2_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.acc       = acc_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed checks of the sequencer against a behavioural BreadBoard model
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [16:0] sum17;
    alu_cmd_sequencer_if #(.DATA_W(16), .RES_W(32)) bus ();
    alu_cmd_sequencer #(.SETTLE_CYCLES(4), .DATA_W(16), .RES_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    // BreadBoard raises ERR bits regardless of opcode, so the sequencer must mask them
    always_comb begin
        sum17 = {1'b0, bus.alu_in1} + {1'b0, bus.alu_in2};
        bus.alu_err = {bus.alu_in2 == 16'd0, bus.alu_op == OP_SUB ? bus.alu_in1 < bus.alu_in2 : sum17[16]};
        bus.alu_out = bus.alu_op == OP_ADD ? 32'(sum17) :
                      bus.alu_op == OP_SUB ? 32'(bus.alu_in1) - 32'(bus.alu_in2) :
                      bus.alu_op == OP_MUL ? 32'(bus.alu_in1) * 32'(bus.alu_in2) :
                      bus.alu_op == OP_DIV ? (bus.alu_in2 == 16'd0 ? 32'd0 : 32'(bus.alu_in1 / bus.alu_in2)) :
                      bus.alu_op == OP_MOD ? (bus.alu_in2 == 16'd0 ? 32'd0 : 32'(bus.alu_in1 % bus.alu_in2)) : 32'd0;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
    endtask
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] in1, input logic [15:0] in2,
                          input logic use_acc, input int exp_lat, input logic [15:0] exp_in1,
                          input logic [31:0] exp_out, input logic [1:0] exp_err, input logic [31:0] exp_acc);
        int lat;
        bus.cmd_op = op;
        bus.cmd_in1 = in1;
        bus.cmd_in2 = in2;
        bus.cmd_acc = use_acc;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("alu_in1", 32'(bus.alu_in1), 32'(exp_in1));
        chk("rsp_out", bus.rsp_out, exp_out);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("acc", bus.acc, exp_acc);
        tick;
        chk("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
    endtask
    task automatic chk_reset_state;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_out", bus.rsp_out, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_acc", bus.acc, 32'd0);
        chk("rst_alu_in1", 32'(bus.alu_in1), 32'd0);
        chk("rst_alu_in2", 32'(bus.alu_in2), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    endtask
    initial begin
        int lat;
        logic seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_in1 = '0;
        bus.cmd_in2 = '0;
        bus.cmd_op = '0;
        bus.cmd_acc = 1'b0;
        bus.rsp_ready = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk_reset_state;
        do_cmd(OP_ADD, 16'd11, 16'd51, 1'b0, 4, 16'd11, 32'd62, 2'b00, 32'd62);
        do_cmd(OP_SUB, 16'd11, 16'd51, 1'b0, 4, 16'd11, 32'hFFFFFFD8, 2'b01, 32'd62);
        do_cmd(OP_DIV, 16'd11, 16'd0, 1'b0, 4, 16'd11, 32'd0, 2'b10, 32'd62);
        do_cmd(OP_MOD, 16'd999, 16'd5, 1'b1, 4, 16'd62, 32'd2, 2'b00, 32'd2);
        do_cmd(OP_MUL, 16'd62091, 16'd47411, 1'b0, 4, 16'd62091, 32'd2943796401, 2'b00, 32'd2943796401);
        // backpressure: second command held valid across a stalled response
        bus.rsp_ready = 1'b0;
        bus.cmd_op = OP_SUB;
        bus.cmd_in1 = 16'd100;
        bus.cmd_in2 = 16'd30;
        bus.cmd_acc = 1'b0;
        bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_op = OP_ADD;
        bus.cmd_in1 = 16'd3;
        bus.cmd_in2 = 16'd4;
        wait_rsp(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_out", bus.rsp_out, 32'd70);
            chk("bp_rsp_err", 32'(bus.rsp_err), 32'd0);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        end
        chk("bp_acc", bus.acc, 32'd70);
        bus.rsp_ready = 1'b1;
        tick;
        chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("hs_no_accept", 32'(bus.alu_in1), 32'd100);
        tick;
        bus.cmd_valid = 1'b0;
        chk("acc2_alu_in1", 32'(bus.alu_in1), 32'd3);
        chk("acc2_alu_in2", 32'(bus.alu_in2), 32'd4);
        chk("acc2_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("acc2_busy", 32'(bus.busy), 32'd1);
        wait_rsp(lat);
        chk("acc2_latency", 32'(lat), 32'd4);
        chk("acc2_rsp_out", bus.rsp_out, 32'd7);
        chk("acc2_acc", bus.acc, 32'd7);
        tick;
        chk("acc2_drop", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
        do_cmd(4'b1000, 16'd5, 16'd0, 1'b0, 0, 16'd3, 32'd0, 2'b11, 32'd7);
        chk("illegal_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
`else
        do_cmd(4'b1000, 16'd5, 16'd0, 1'b0, 4, 16'd5, 32'd0, 2'b00, 32'd7);
        chk("illegal_alu_op", 32'(bus.alu_op), 32'd8);
`endif
        // reset during SETTLE abandons the command
        bus.cmd_op = OP_ADD;
        bus.cmd_in1 = 16'd1;
        bus.cmd_in2 = 16'd2;
        bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset_state;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            seen |= bus.rsp_valid;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_idle_ready", 32'(bus.cmd_ready), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
